real_ball_collector: RTL and testbench



---
 rtl/juggle_pkg.sv | 29 ++
 rtl/sorted_insert_buf.sv | 99 +++++++++
 rtl/real_ball_collector.sv | 85 ++++++++
 tb/tb_real_ball_collector.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/juggle_pkg.sv
// ---------------------------------------------------------------------------
// juggle_pkg : shared widths and types for the ball-tracking pipeline
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package juggle_pkg;

  localparam int X_W       = 11;
  localparam int Y_W       = 10;
  localparam int AREA_W    = 17;
  localparam int MAX_BALLS = 7;
  localparam int CNT_W     = 3;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } ball_pos_t;

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [AREA_W-1:0] area;
    logic              valid;
  } cand_t;

endpackage

`default_nettype wire

// File: rtl/sorted_insert_buf.sv
// ---------------------------------------------------------------------------
// sorted_insert_buf : descending-by-area insertion buffer, single-cycle insert
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sorted_insert_buf
  import juggle_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic [CNT_W-1:0]             clear_cap,
  input  logic                         insert,
  input  logic [X_W-1:0]               ins_x,
  input  logic [Y_W-1:0]               ins_y,
  input  logic [AREA_W-1:0]            ins_area,
  output ball_pos_t [MAX_BALLS-1:0]    slots,
  output logic [CNT_W-1:0]             count,
  output logic                         overflow
);

  cand_t [MAX_BALLS-1:0] r_bank;
  cand_t [MAX_BALLS-1:0] w_base;
  cand_t [MAX_BALLS-1:0] w_next;
  cand_t                 w_new;
  logic [CNT_W-1:0]      r_cap;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_base_cap;
  logic [CNT_W-1:0]      w_base_count;
  logic [CNT_W-1:0]      w_next_count;
  logic                  r_ovf;
  logic                  w_base_ovf;
  logic                  w_next_ovf;
  logic                  w_found;
  logic                  w_last_valid;
  int                    w_k;
  int                    w_cap_i;

  // A clear in the same cycle as an insert makes the insert land in the empty bank.
  always_comb begin
    w_base_cap   = clear ? clear_cap : r_cap;
    w_base_count = clear ? '0 : r_count;
    w_base_ovf   = clear ? 1'b0 : r_ovf;
    w_base       = clear ? '0 : r_bank;
    w_cap_i      = int'(w_base_cap);
    w_new        = '{x: ins_x, y: ins_y, area: ins_area, valid: 1'b1};
    w_found      = 1'b0;
    w_k          = 0;
    w_last_valid = 1'b0;
    for (int i = 0; i < MAX_BALLS; i++) begin
      if (!w_found && (i < w_cap_i) &&
          (!w_base[i].valid || (w_base[i].area < ins_area))) begin
        w_found = 1'b1;
        w_k     = i;
      end
      if (i == w_cap_i - 1) w_last_valid = w_base[i].valid;
    end

    w_next       = w_base;
    w_next_count = w_base_count;
    w_next_ovf   = w_base_ovf;
    if (insert) begin
      for (int i = 1; i < MAX_BALLS; i++) begin
        if (w_found && (i > w_k) && (i < w_cap_i)) w_next[i] = w_base[i-1];
      end
      for (int i = 0; i < MAX_BALLS; i++) begin
        if (w_found && (i == w_k)) w_next[i] = w_new;
      end
      // Either the new entry found no room, or the last occupied slot was displaced.
      if (!w_found || w_last_valid) w_next_ovf = 1'b1;
      if (w_base_count < w_base_cap) w_next_count = w_base_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank  <= '0;
      r_cap   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_bank  <= w_next;
      r_cap   <= w_base_cap;
      r_count <= w_next_count;
      r_ovf   <= w_next_ovf;
    end
  end

  for (genvar g = 0; g < MAX_BALLS; g++) begin : g_slots
    assign slots[g] = '{x: r_bank[g].x, y: r_bank[g].y};
  end

  assign count    = r_count;
  assign overflow = r_ovf;

endmodule

`default_nettype wire

// File: rtl/real_ball_collector.sv
// ---------------------------------------------------------------------------
// real_ball_collector : keeps the largest blobs per frame, emits a snapshot
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module real_ball_collector
  import juggle_pkg::*;
#(
  parameter int MIN_AREA    = 16,
  parameter int OFFSCREEN_X = 2047,
  parameter int OFFSCREEN_Y = 1023
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            nf_in,
  input  logic [CNT_W-1:0]                num_balls_in,
  input  logic                            centroid_valid_in,
  input  logic [X_W-1:0]                  centroid_x_in,
  input  logic [Y_W-1:0]                  centroid_y_in,
  input  logic [AREA_W-1:0]               centroid_area_in,
  input  logic                            eval_ready_in,
  output logic                            data_valid_out,
  output logic [MAX_BALLS-1:0][X_W-1:0]   real_balls_x_out,
  output logic [MAX_BALLS-1:0][Y_W-1:0]   real_balls_y_out,
  output logic [CNT_W-1:0]                num_found_out,
  output logic                            overflow_out,
  output logic [7:0]                      frames_dropped_out
);

  ball_pos_t [MAX_BALLS-1:0] w_slots;
  logic [CNT_W-1:0]          w_count;
  logic                      w_ovf;
  logic                      r_started;
  logic                      w_start;
  logic                      w_insert;

  // The first cycle out of reset opens a frame so the cap gets latched.
  assign w_start  = nf_in | ~r_started;
  assign w_insert = centroid_valid_in && (centroid_area_in >= AREA_W'(MIN_AREA));

  sorted_insert_buf u_buf (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .clear     (w_start),
    .clear_cap (num_balls_in),
    .insert    (w_insert),
    .ins_x     (centroid_x_in),
    .ins_y     (centroid_y_in),
    .ins_area  (centroid_area_in),
    .slots     (w_slots),
    .count     (w_count),
    .overflow  (w_ovf)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_started          <= 1'b0;
      data_valid_out     <= 1'b0;
      real_balls_x_out   <= {MAX_BALLS{X_W'(OFFSCREEN_X)}};
      real_balls_y_out   <= {MAX_BALLS{Y_W'(OFFSCREEN_Y)}};
      num_found_out      <= '0;
      overflow_out       <= 1'b0;
      frames_dropped_out <= '0;
    end else begin
      r_started      <= 1'b1;
      data_valid_out <= nf_in && eval_ready_in;
      if (nf_in) begin
        if (eval_ready_in) begin
          for (int i = 0; i < MAX_BALLS; i++) begin
            real_balls_x_out[i] <= (i < int'(w_count)) ? w_slots[i].x : X_W'(OFFSCREEN_X);
            real_balls_y_out[i] <= (i < int'(w_count)) ? w_slots[i].y : Y_W'(OFFSCREEN_Y);
          end
          num_found_out <= w_count;
          overflow_out  <= w_ovf;
        end else if (frames_dropped_out != 8'hFF) begin
          frames_dropped_out <= frames_dropped_out + 8'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_real_ball_collector.sv
// ---------------------------------------------------------------------------
// tb_real_ball_collector : scoreboard bench for real_ball_collector
// Revision               : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_real_ball_collector;
  import juggle_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          nf;
  logic [2:0]                    nb;
  logic                          cv;
  logic [10:0]                   cx;
  logic [9:0]                    cy;
  logic [16:0]                   ca;
  logic                          ready;
  logic                          dv;
  logic [6:0][10:0]              bx;
  logic [6:0][9:0]               by;
  logic [2:0]                    nfound;
  logic                          ovf;
  logic [7:0]                    dropped;

  always #5 clk = ~clk;

  real_ball_collector dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n),
    .nf_in              (nf),
    .num_balls_in       (nb),
    .centroid_valid_in  (cv),
    .centroid_x_in      (cx),
    .centroid_y_in      (cy),
    .centroid_area_in   (ca),
    .eval_ready_in      (ready),
    .data_valid_out     (dv),
    .real_balls_x_out   (bx),
    .real_balls_y_out   (by),
    .num_found_out      (nfound),
    .overflow_out       (ovf),
    .frames_dropped_out (dropped)
  );

  typedef struct packed {
    logic [76:0] x;
    logic [69:0] y;
    logic [2:0]  nf;
    logic        ovf;
  } snap_t;

  snap_t exp_q[$];
  snap_t last_snap;
  int    q_x[$];
  int    q_y[$];
  int    q_a[$];
  int    m_cap;
  bit    m_ovf;
  int    m_dropped;
  int    total = 0;
  int    bad   = 0;

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic snap_t reset_snap();
    snap_t s;
    for (int i = 0; i < 7; i++) begin
      s.x[i*11 +: 11] = 11'd2047;
      s.y[i*10 +: 10] = 10'd1023;
    end
    s.nf  = 3'd0;
    s.ovf = 1'b0;
    return s;
  endfunction

  function automatic snap_t m_snapshot();
    snap_t s;
    s = reset_snap();
    for (int i = 0; i < q_x.size(); i++) begin
      s.x[i*11 +: 11] = 11'(q_x[i]);
      s.y[i*10 +: 10] = 10'(q_y[i]);
    end
    s.nf  = 3'(q_x.size());
    s.ovf = m_ovf;
    return s;
  endfunction

  task automatic m_frame_start();
    q_x.delete();
    q_y.delete();
    q_a.delete();
    m_cap = int'(nb);
    m_ovf = 1'b0;
  endtask

  task automatic m_accept(int x, int y, int a);
    int  p;
    bit  placed;
    if (a < 16) return;
    p      = q_a.size();
    placed = 1'b0;
    for (int i = 0; i < q_a.size(); i++) begin
      if (!placed && q_a[i] < a) begin
        p      = i;
        placed = 1'b1;
      end
    end
    q_x.insert(p, x);
    q_y.insert(p, y);
    q_a.insert(p, a);
    while (q_a.size() > m_cap) begin
      void'(q_x.pop_back());
      void'(q_y.pop_back());
      void'(q_a.pop_back());
      m_ovf = 1'b1;
    end
  endtask

  task automatic send(int x, int y, int a);
    @(negedge clk);
    nf = 1'b0;
    cv = 1'b1;
    cx = 11'(x);
    cy = 10'(y);
    ca = 17'(a);
    m_accept(x, y, a);
  endtask

  task automatic send_nf(bit rdy, bit with_c, int x, int y, int a);
    snap_t s;
    snap_t e;
    @(negedge clk);
    nf    = 1'b1;
    ready = rdy;
    cv    = with_c;
    cx    = 11'(x);
    cy    = 10'(y);
    ca    = 17'(a);
    s = m_snapshot();
    if (rdy) exp_q.push_back(s);
    else if (m_dropped < 255) m_dropped++;
    m_frame_start();
    if (with_c) m_accept(x, y, a);
    @(posedge clk);
    #1;
    if (rdy) begin
      check("strobe", dv, 1);
      e = exp_q.pop_front();
      check("snap_x", bx, e.x);
      check("snap_y", by, e.y);
      check("num_found", nfound, e.nf);
      check("overflow", ovf, e.ovf);
      last_snap = e;
    end else begin
      check("no_strobe", dv, 0);
      check("hold_x", bx, last_snap.x);
      check("hold_num_found", nfound, last_snap.nf);
    end
    check("dropped", dropped, m_dropped);
    @(negedge clk);
    nf = 1'b0;
    cv = 1'b0;
    if (rdy) begin
      @(posedge clk);
      #1;
      check("strobe_len", dv, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    nf    = 1'b0;
    nb    = 3'd3;
    cv    = 1'b0;
    cx    = '0;
    cy    = '0;
    ca    = '0;
    ready = 1'b1;
    last_snap = reset_snap();
    m_dropped = 0;
    repeat (3) @(negedge clk);
    check("rst_valid", dv, 0);
    check("rst_x", bx, last_snap.x);
    check("rst_y", by, last_snap.y);
    check("rst_num_found", nfound, 0);
    check("rst_overflow", ovf, 0);
    check("rst_dropped", dropped, 0);
    rst_n = 1'b1;
    m_frame_start();

    // Sorting with cap 3
    send(10, 11, 50);
    send(20, 21, 200);
    send(30, 31, 100);
    nb = 3'd2;
    send_nf(1, 0, 0, 0, 0);

    // Cap 2 overflow
    send(40, 41, 100);
    send(50, 51, 300);
    send(60, 61, 200);
    nb = 3'd3;
    send_nf(1, 0, 0, 0, 0);

    // Minimum-area filter
    send(70, 71, 10);
    send(80, 81, 80);
    send(90, 91, 15);
    nb = 3'd2;
    send_nf(1, 0, 0, 0, 0);

    // Equal areas keep arrival order; mid-frame cap change is ignored
    send(100, 101, 120);
    nb = 3'd5;
    send(110, 111, 120);
    send(120, 121, 120);
    nb = 3'd7;
    send_nf(1, 0, 0, 0, 0);

    // Coincident centroid belongs to the new frame
    send(130, 131, 500);
    send(140, 141, 40);
    send_nf(1, 1, 150, 151, 900);
    send(160, 161, 16);
    send_nf(1, 0, 0, 0, 0);

    // Drops, saturating at 255
    send(170, 171, 77);
    for (int i = 0; i < 300; i++) send_nf(0, 0, 0, 0, 0);
    check("drop_sat", dropped, 8'd255);
    nb = 3'd0;
    send_nf(1, 0, 0, 0, 0);

    // Cap 0: any qualifying centroid overflows
    send(180, 181, 100);
    nb = 3'd4;
    send_nf(1, 0, 0, 0, 0);

    // Reset mid-frame discards the bank
    send(190, 191, 60);
    send(200, 201, 70);
    @(negedge clk);
    cv    = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", dv, 0);
    check("midrst_x", bx, reset_snap().x);
    check("midrst_num_found", nfound, 0);
    check("midrst_dropped", dropped, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    m_dropped = 0;
    last_snap = reset_snap();
    m_frame_start();
    send_nf(1, 0, 0, 0, 0);
    send(210, 211, 33);
    send_nf(1, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
